// File: rtl/asrv32_writeback_ctrl_pkg.sv
// Shared encodings for the asrv32 writeback stage.
package asrv32_writeback_ctrl_pkg;

  // One-hot opcode vector layout (RTYPE..FENCE); only LOAD and SYSTEM are decoded here.
  localparam int unsigned OPCODE_WIDTH = 11;
  localparam int unsigned OPC_RTYPE    = 0;
  localparam int unsigned OPC_LOAD     = 2;
  localparam int unsigned OPC_SYSTEM   = 9;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_WAIT_LOAD = 2'd1,
    WB_FLUSH     = 2'd2
  } wb_state_e;

  // Load context captured while waiting for memory.
  typedef struct packed {
    logic       wr_en;
    logic [4:0] rd_addr;
    logic [2:0] funct3;
    logic [1:0] lsb;
  } load_ctx_t;

endpackage

// File: rtl/asrv32_writeback_ctrl_load_align.sv
// Combinational load data extraction: byte/half select with sign or zero extension.
module asrv32_writeback_ctrl_load_align
  import asrv32_writeback_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lsb,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword from the raw word.
  always_comb begin
    byte_sel = raw[7:0];
    case (lsb)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = lsb[1] ? raw[31:16] : raw[15:0];
  end

  // Extend to XLEN according to the load type; unknown encodings yield zero.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(byte_sel));
      F3_LH:   result = XLEN'($signed(half_sel));
      F3_LW:   result = XLEN'($signed(raw[31:0]));
      F3_LBU:  result = XLEN'(byte_sel);
      F3_LHU:  result = XLEN'(half_sel);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/asrv32_writeback_ctrl.sv
// Registered writeback stage: rd write port, PC redirect, load wait/timeout and post-redirect flush.
module asrv32_writeback_ctrl
  import asrv32_writeback_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] PC_RESET     = '0,
  parameter int unsigned     LOAD_TIMEOUT = 16,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ce,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [1:0]              i_addr_lsb,
  input  logic                    i_wr_rd_en,
  input  logic [4:0]              i_rd_addr,
  input  logic [XLEN-1:0]         i_rd_data,
  input  logic [XLEN-1:0]         i_load_data_from_memory,
  input  logic                    i_load_ack,
  input  logic [XLEN-1:0]         i_load_data_from_csr,
  input  logic                    i_go_to_trap,
  input  logic                    i_return_from_trap,
  input  logic [XLEN-1:0]         i_trap_address,
  input  logic [XLEN-1:0]         i_return_address,
  output logic                    o_wr_rd_en,
  output logic [4:0]              o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
  output logic                    o_change_pc,
  output logic [XLEN-1:0]         o_next_pc,
  output logic                    o_flush,
  output logic                    o_stall,
  output logic                    o_load_fault
);

  localparam int unsigned CNT_MAX = (LOAD_TIMEOUT > FLUSH_CYCLES) ? LOAD_TIMEOUT : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  wb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  load_ctx_t       ctx, ctx_nxt;
  logic            wr_en_nxt, change_pc_nxt, fault_nxt;
  logic [4:0]      rd_addr_nxt;
  logic [XLEN-1:0] rd_data_nxt, next_pc_nxt;
  logic            is_load, is_csr, redirect;
  logic [XLEN-1:0] redirect_pc, load_result;
  logic [2:0]      align_f3;
  logic [1:0]      align_lsb;
  logic            unused_opcode_bits;

  assign unused_opcode_bits = ^i_opcode;

  // Decode and trap-over-mret target selection.
  assign is_load     = i_opcode[OPC_LOAD];
  assign is_csr      = i_opcode[OPC_SYSTEM] && (i_funct3 != 3'b000);
  assign redirect    = i_go_to_trap || i_return_from_trap;
  assign redirect_pc = i_go_to_trap ? i_trap_address : i_return_address;

  // Pending loads align with the captured funct3/lsb, fresh loads with the live ones.
  assign align_f3  = (state == WB_WAIT_LOAD) ? ctx.funct3 : i_funct3;
  assign align_lsb = (state == WB_WAIT_LOAD) ? ctx.lsb    : i_addr_lsb;

  asrv32_writeback_ctrl_load_align #(.XLEN(XLEN)) u_align (
    .raw    (i_load_data_from_memory),
    .funct3 (align_f3),
    .lsb    (align_lsb),
    .result (load_result)
  );

  // Upstream stall, combinational so a missing ack holds the pipe in the same cycle.
  assign o_stall = (state == WB_WAIT_LOAD) || (state == WB_FLUSH) ||
                   ((state == WB_IDLE) && i_ce && is_load && !i_load_ack);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ctx_nxt       = ctx;
    wr_en_nxt     = 1'b0;
    rd_addr_nxt   = o_rd_addr;
    rd_data_nxt   = o_rd_data;
    change_pc_nxt = 1'b0;
    next_pc_nxt   = o_next_pc;
    fault_nxt     = 1'b0;
    unique case (state)
      WB_IDLE: begin
        if (i_ce) begin
          if (redirect) begin
            change_pc_nxt = 1'b1;
            next_pc_nxt   = redirect_pc;
            cnt_nxt       = '0;
            state_nxt     = WB_FLUSH;
          end else if (is_load) begin
            if (i_load_ack) begin
              wr_en_nxt   = i_wr_rd_en && (i_rd_addr != 5'd0);
              rd_addr_nxt = i_rd_addr;
              rd_data_nxt = load_result;
            end else begin
              ctx_nxt   = '{wr_en: i_wr_rd_en, rd_addr: i_rd_addr, funct3: i_funct3, lsb: i_addr_lsb};
              cnt_nxt   = '0;
              state_nxt = WB_WAIT_LOAD;
            end
          end else begin
            wr_en_nxt   = i_wr_rd_en && (i_rd_addr != 5'd0);
            rd_addr_nxt = i_rd_addr;
            rd_data_nxt = is_csr ? i_load_data_from_csr : i_rd_data;
          end
        end
      end
      WB_WAIT_LOAD: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (redirect) begin
          change_pc_nxt = 1'b1;
          next_pc_nxt   = redirect_pc;
          cnt_nxt       = '0;
          state_nxt     = WB_FLUSH;
        end else if (i_load_ack) begin
          wr_en_nxt   = ctx.wr_en && (ctx.rd_addr != 5'd0);
          rd_addr_nxt = ctx.rd_addr;
          rd_data_nxt = load_result;
          cnt_nxt     = '0;
          state_nxt   = WB_IDLE;
        end else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
          fault_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WB_IDLE;
        end
      end
      WB_FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = WB_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = WB_IDLE;
      end
    endcase
  end

  // State, counter, load context and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= WB_IDLE;
      cnt          <= '0;
      ctx          <= '0;
      o_wr_rd_en   <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_change_pc  <= 1'b0;
      o_next_pc    <= PC_RESET;
      o_flush      <= 1'b0;
      o_load_fault <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ctx          <= ctx_nxt;
      o_wr_rd_en   <= wr_en_nxt;
      o_rd_addr    <= rd_addr_nxt;
      o_rd_data    <= rd_data_nxt;
      o_change_pc  <= change_pc_nxt;
      o_next_pc    <= next_pc_nxt;
      o_flush      <= (state_nxt == WB_FLUSH);
      o_load_fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_asrv32_writeback_ctrl.sv
// Scoreboard bench for asrv32_writeback_ctrl: expected rd writes queued at issue, checked when written.
module tb_asrv32_writeback_ctrl;
  import asrv32_writeback_ctrl_pkg::*;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned LOAD_TIMEOUT = 16;
  localparam int unsigned FLUSH_CYCLES = 3;
  localparam logic [31:0] PC_RESET     = 32'h8000_0000;

  logic                    i_clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic                    i_ce;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic [2:0]              i_funct3;
  logic [1:0]              i_addr_lsb;
  logic                    i_wr_rd_en;
  logic [4:0]              i_rd_addr;
  logic [31:0]             i_rd_data, i_load_data_from_memory, i_load_data_from_csr;
  logic                    i_load_ack, i_go_to_trap, i_return_from_trap;
  logic [31:0]             i_trap_address, i_return_address;
  logic                    o_wr_rd_en, o_change_pc, o_flush, o_stall, o_load_fault;
  logic [4:0]              o_rd_addr;
  logic [31:0]             o_rd_data, o_next_pc;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  asrv32_writeback_ctrl #(
    .XLEN(XLEN), .PC_RESET(PC_RESET), .LOAD_TIMEOUT(LOAD_TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_addr_lsb(i_addr_lsb), .i_wr_rd_en(i_wr_rd_en), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_load_data_from_memory(i_load_data_from_memory), .i_load_ack(i_load_ack),
    .i_load_data_from_csr(i_load_data_from_csr), .i_go_to_trap(i_go_to_trap),
    .i_return_from_trap(i_return_from_trap), .i_trap_address(i_trap_address),
    .i_return_address(i_return_address), .o_wr_rd_en(o_wr_rd_en), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_change_pc(o_change_pc), .o_next_pc(o_next_pc), .o_flush(o_flush),
    .o_stall(o_stall), .o_load_fault(o_load_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_in();
    i_ce = 1'b0; i_opcode = '0; i_funct3 = '0; i_addr_lsb = '0; i_wr_rd_en = 1'b0;
    i_rd_addr = '0; i_rd_data = '0; i_load_data_from_memory = '0; i_load_ack = 1'b0;
    i_load_data_from_csr = '0; i_go_to_trap = 1'b0; i_return_from_trap = 1'b0;
    i_trap_address = '0; i_return_address = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    clear_in();
    i_ce = 1'b1; i_opcode[OPC_RTYPE] = 1'b1; i_wr_rd_en = 1'b1; i_rd_addr = rd; i_rd_data = data;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [4:0] rd,
                            input logic [31:0] mem, input logic ack);
    clear_in();
    i_ce = 1'b1; i_opcode[OPC_LOAD] = 1'b1; i_funct3 = f3; i_addr_lsb = lsb; i_wr_rd_en = 1'b1;
    i_rd_addr = rd; i_load_data_from_memory = mem; i_load_ack = ack;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] mem, input logic [2:0] f3,
                                             input logic [1:0] lsb);
    logic [31:0] b, h;
    b = mem >> (int'(lsb) * 8);
    h = mem >> (lsb[1] ? 16 : 0);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b010:  return mem;
      3'b100:  return {24'h0, b[7:0]};
      3'b101:  return {16'h0, h[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Scoreboard: every rd write must match the oldest expected entry.
  always @(negedge i_clk) begin
    wr_t e;
    if (!i_rst && o_wr_rd_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {59'h0, o_rd_addr}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {59'h0, o_rd_addr}, {59'h0, e.addr});
        check("wr_data", {32'h0, o_rd_data}, {32'h0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          waited;
    logic        seen;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [2:0]  f3_tab [5];
    f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW; f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;

    clear_in();
    tick(); tick();
    check("rst_wr_en", {63'h0, o_wr_rd_en}, 64'h0);
    check("rst_next_pc", {32'h0, o_next_pc}, {32'h0, PC_RESET});
    check("rst_flush", {63'h0, o_flush}, 64'h0);
    check("rst_stall", {63'h0, o_stall}, 64'h0);
    i_rst = 1'b0;
    tick();

    // ALU result, then rd=0 suppressed.
    drive_alu(5'd5, 32'h1234);
    exp_q.push_back('{addr: 5'd5, data: 32'h1234});
    tick();
    check("alu_wr_en", {63'h0, o_wr_rd_en}, 64'h1);
    drive_alu(5'd0, 32'h5555);
    tick();
    check("rd0_no_wr", {63'h0, o_wr_rd_en}, 64'h0);

    // CSR read selects the CSR value.
    drive_alu(5'd7, 32'h1111);
    i_opcode = '0; i_opcode[OPC_SYSTEM] = 1'b1; i_funct3 = 3'b001; i_load_data_from_csr = 32'hABCD;
    exp_q.push_back('{addr: 5'd7, data: 32'hABCD});
    tick();

    // Acked loads from the spec plus a random mix.
    drive_load(F3_LB, 2'd2, 5'd8, 32'h0080_0000, 1'b1);
    exp_q.push_back('{addr: 5'd8, data: 32'hFFFF_FF80});
    #1 check("ack_load_no_stall", {63'h0, o_stall}, 64'h0);
    tick();
    drive_load(F3_LHU, 2'd2, 5'd8, 32'h8001_0000, 1'b1);
    exp_q.push_back('{addr: 5'd8, data: 32'h0000_8001});
    tick();
    drive_load(3'b011, 2'd0, 5'd9, 32'hFFFF_FFFF, 1'b1);
    exp_q.push_back('{addr: 5'd9, data: 32'h0});
    tick();
    for (int i = 0; i < 10; i++) begin
      f3  = f3_tab[$urandom_range(0, 4)];
      lsb = 2'($urandom_range(0, 3));
      if (f3 == F3_LW) lsb = 2'd0;
      if (f3 == F3_LH || f3 == F3_LHU) lsb[0] = 1'b0;
      rd  = 5'($urandom_range(1, 31));
      mem = $urandom();
      drive_load(f3, lsb, rd, mem, 1'b1);
      exp_q.push_back('{addr: rd, data: model_load(mem, f3, lsb)});
      tick();
    end

    // LW waits three cycles; live rd/funct3 change mid-wait must not matter.
    drive_load(F3_LW, 2'd0, 5'd9, 32'h0, 1'b0);
    waited = 0;
    #1 if (o_stall) waited++;
    tick();
    clear_in(); i_rd_addr = 5'd3; i_funct3 = F3_LB;
    for (int i = 0; i < 2; i++) begin
      #1 if (o_stall) waited++;
      tick();
      check("wait_no_wr", {63'h0, o_wr_rd_en}, 64'h0);
    end
    i_load_ack = 1'b1; i_load_data_from_memory = 32'hDEAD_BEEF;
    exp_q.push_back('{addr: 5'd9, data: 32'hDEAD_BEEF});
    #1 if (o_stall) waited++;
    tick();
    check("wait_wr_en", {63'h0, o_wr_rd_en}, 64'h1);
    clear_in();
    #1 check("wait_stall_cycles", 64'(waited), 64'd4);
    check("wait_back_idle", {63'h0, o_stall}, 64'h0);

    // Never acked: fault after LOAD_TIMEOUT cycles in WAIT_LOAD.
    drive_load(F3_LW, 2'd0, 5'd10, 32'h0, 1'b0);
    tick();
    clear_in();
    waited = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      waited++;
      if (o_load_fault) seen = 1'b1;
    end
    check("timeout_seen", {63'h0, seen}, 64'h1);
    check("timeout_cycles", 64'(waited), 64'(LOAD_TIMEOUT));
    check("timeout_no_wr", {63'h0, o_wr_rd_en}, 64'h0);
    tick();
    check("fault_pulse", {63'h0, o_load_fault}, 64'h0);
    check("timeout_idle", {63'h0, o_stall}, 64'h0);

    // Ack in the final timeout cycle wins over the fault.
    drive_load(F3_LW, 2'd0, 5'd11, 32'h0, 1'b0);
    tick();
    clear_in();
    repeat (LOAD_TIMEOUT - 1) tick();
    i_load_ack = 1'b1; i_load_data_from_memory = 32'hCAFE_F00D;
    exp_q.push_back('{addr: 5'd11, data: 32'hCAFE_F00D});
    tick();
    check("last_ack_no_fault", {63'h0, o_load_fault}, 64'h0);
    check("last_ack_wr", {63'h0, o_wr_rd_en}, 64'h1);
    clear_in();
    tick();

    // Trap and mret together: trap wins; instructions during flush ignored.
    drive_alu(5'd4, 32'h4444);
    i_go_to_trap = 1'b1; i_return_from_trap = 1'b1;
    i_trap_address = 32'h100; i_return_address = 32'h200;
    tick();
    check("trap_change_pc", {63'h0, o_change_pc}, 64'h1);
    check("trap_next_pc", {32'h0, o_next_pc}, 64'h100);
    check("trap_flush", {63'h0, o_flush}, 64'h1);
    check("trap_no_wr", {63'h0, o_wr_rd_en}, 64'h0);
    check("flush_stall", {63'h0, o_stall}, 64'h1);
    drive_alu(5'd6, 32'h6666);
    for (int i = 1; i < int'(FLUSH_CYCLES); i++) begin
      tick();
      check("flush_held", {63'h0, o_flush}, 64'h1);
      check("change_pc_pulse", {63'h0, o_change_pc}, 64'h0);
    end
    clear_in();
    tick();
    check("flush_done", {63'h0, o_flush}, 64'h0);
    check("flush_done_stall", {63'h0, o_stall}, 64'h0);
    check("next_pc_held", {32'h0, o_next_pc}, 64'h100);

    // MRET alone.
    drive_alu(5'd4, 32'h4444);
    i_return_from_trap = 1'b1; i_return_address = 32'h200;
    tick();
    check("mret_next_pc", {32'h0, o_next_pc}, 64'h200);
    check("mret_change_pc", {63'h0, o_change_pc}, 64'h1);
    clear_in();
    repeat (FLUSH_CYCLES) tick();

    // Trap while waiting for a load abandons it even with a simultaneous ack.
    drive_load(F3_LW, 2'd0, 5'd12, 32'h0, 1'b0);
    tick();
    clear_in();
    i_go_to_trap = 1'b1; i_trap_address = 32'h300; i_load_ack = 1'b1;
    tick();
    check("wait_trap_pc", {32'h0, o_next_pc}, 64'h300);
    check("wait_trap_no_wr", {63'h0, o_wr_rd_en}, 64'h0);
    clear_in();
    repeat (FLUSH_CYCLES) tick();

    // Reset in the middle of a load wait; later ack ignored.
    drive_load(F3_LW, 2'd0, 5'd13, 32'h0, 1'b0);
    tick();
    clear_in();
    tick();
    i_rst = 1'b1;
    #1;
    check("mid_rst_stall", {63'h0, o_stall}, 64'h0);
    check("mid_rst_next_pc", {32'h0, o_next_pc}, {32'h0, PC_RESET});
    check("mid_rst_rd_data", {32'h0, o_rd_data}, 64'h0);
    check("mid_rst_flush", {63'h0, o_flush}, 64'h0);
    tick();
    i_rst = 1'b0;
    i_load_ack = 1'b1; i_load_data_from_memory = 32'h1357_9BDF;
    tick();
    check("post_rst_no_wr", {63'h0, o_wr_rd_en}, 64'h0);
    check("post_rst_no_fault", {63'h0, o_load_fault}, 64'h0);
    clear_in();
    tick(); tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
